// File: rtl/clfsr_pkg.sv
// Shared types and constants for the chaos-LFSR key generator.
package clfsr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  localparam logic [15:0] X_DEFAULT    = 16'h0001;

  // Chaos state is Q0.16, r is Q2.14, product x*(1-x) is 33 bits wide
  localparam int X_W    = 16;
  localparam int R_W    = 16;
  localparam int R_FRAC = 14;
  localparam int P_W    = 2*X_W + 1;
  localparam int CNT_W  = 8;

  function automatic logic [15:0] lfsr_seed(input logic [15:0] s);
    return (s == '0) ? SEED_DEFAULT : s;
  endfunction

endpackage

// File: rtl/clfsr_lfsr16.sv
// One Galois right-shift step of a 16-bit LFSR, optional XOR mix-in, and
// a guard that keeps the register out of the all-zero lock-up state.
module clfsr_lfsr16
  import clfsr_pkg::*;
(
  input  logic [15:0] cur,
  input  logic [15:0] mix,
  output logic [15:0] nxt
);

  logic [15:0] stepped;
  logic [15:0] mixed;

  always_comb begin
    stepped = (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
    mixed   = stepped ^ mix;
    nxt     = (mixed == '0) ? SEED_DEFAULT : mixed;
  end

endmodule

// File: rtl/clfsr_keygen.sv
// Key-byte generator: three Galois LFSRs, optionally mixed with a logistic map.
// Define CLFSR_CHAOS_EN to build the chaos map, perturbation and output mixing.
module clfsr_keygen
  import clfsr_pkg::*;
#(
  parameter int          WARMUP_CYCLES  = 64,
  parameter int          PERTURB_PERIOD = 16,
  parameter logic [15:0] R_COEF         = 16'hF8F5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_valid,
  input  logic [15:0] seed_r,
  input  logic [15:0] seed_g,
  input  logic [15:0] seed_b,
  input  logic [15:0] seed_x,
  input  logic        advance,
  output logic        Key_ready,
  output logic [7:0]  R_random,
  output logic [7:0]  G_random,
  output logic [7:0]  B_random
);

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);

  state_t               state, state_nxt;
  logic                 step;
  logic [CNT_W-1:0]     warm_cnt;
  logic [2:0][15:0]     seed;
  logic [2:0][15:0]     lfsr;
  logic [2:0][15:0]     lfsr_nxt;
  logic [15:0]          mix;

  assign seed = {seed_b, seed_g, seed_r};

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state; a seed strobe restarts from any state
  always_comb begin
    state_nxt = state;
    if (seed_valid) begin
      state_nxt = WARMUP;
    end else begin
      case (state)
        WARMUP:  if (warm_cnt == WARM_LAST) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    Key_ready = (state == RUN);
    step      = !seed_valid && ((state == WARMUP) || (state == RUN && advance));
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    clfsr_lfsr16 u_lfsr (
      .cur (lfsr[i]),
      .mix (mix),
      .nxt (lfsr_nxt[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr     <= {3{SEED_DEFAULT}};
      warm_cnt <= '0;
    end else if (seed_valid) begin
      for (int i = 0; i < 3; i++) lfsr[i] <= lfsr_seed(seed[i]);
      warm_cnt <= '0;
    end else if (step) begin
      lfsr <= lfsr_nxt;
      if (state == WARMUP) warm_cnt <= warm_cnt + 1'b1;
    end
  end

`ifdef CLFSR_CHAOS_EN
  localparam logic [CNT_W-1:0] PERT_LAST = CNT_W'(PERTURB_PERIOD - 1);

  logic [X_W-1:0]   x;
  logic [X_W-1:0]   x_step;
  logic [X_W-1:0]   x_nxt;
  logic [P_W-1:0]   p;
  logic [2*R_W-1:0] t;
  logic [CNT_W-1:0] pert_cnt;
  logic             perturb;
  logic             unused_bits;

  // x_next = r * x * (1 - x), realigned from Q2.14 * Q0.16 back to Q0.16
  always_comb begin
    p       = {17'd0, x} * (33'h1_0000 - {17'd0, x});
    t       = {16'd0, R_COEF} * {16'd0, p[31:16]};
    x_step  = t[R_FRAC+X_W-1:R_FRAC];
    x_nxt   = (x_step == '0) ? X_DEFAULT : x_step;
    perturb = (state == RUN) && step && (pert_cnt == PERT_LAST);
    mix     = perturb ? x : 16'h0000;
  end

  assign unused_bits = ^{p[32], p[15:0], t[31:30], t[13:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= X_DEFAULT;
      pert_cnt <= '0;
    end else if (seed_valid) begin
      x        <= (seed_x == '0) ? X_DEFAULT : seed_x;
      pert_cnt <= '0;
    end else if (step) begin
      x <= x_nxt;
      if (state == RUN) pert_cnt <= perturb ? '0 : pert_cnt + 1'b1;
    end
  end

  always_comb begin
    R_random = lfsr[0][7:0] ^ x[15:8];
    G_random = lfsr[1][7:0] ^ x[7:0];
    B_random = lfsr[2][7:0] ^ x[15:8] ^ x[7:0];
  end
`else
  logic unused_seed_x;

  assign unused_seed_x = ^seed_x;
  assign mix           = 16'h0000;

  always_comb begin
    R_random = lfsr[0][7:0];
    G_random = lfsr[1][7:0];
    B_random = lfsr[2][7:0];
  end
`endif

endmodule
